// File: rtl/avl_mem_responder.sv
// -----------------------------------------------------------------------------
// avl_mem_responder
//   Avalon-MM slave memory model. Accepts word-addressed bursts (one address
//   per beat), commits write beats with byte enables into an on-chip RAM and
//   returns read bursts through a fixed-latency pipeline. Used in place of
//   the DDR controller in simulation and small on-chip builds.
//
// Ports
//   clock            in   single rising-edge clock
//   resetn           in   asynchronous active-low reset
//   s_address        in   beat address of the burst (upper bits ignored)
//   s_read           in   read command
//   s_write          in   write beat
//   s_writedata      in   write beat data
//   s_be             in   byte enables, bit i gates byte i
//   s_burstcount     in   beats in the burst, 1..64
//   s_waitrequest    out  stall: command/beat not accepted while high
//   s_readdata       out  read beat data
//   s_readdatavalid  out  s_readdata valid this cycle
//   proto_err        out  sticky protocol-error flag (cleared by reset only)
// -----------------------------------------------------------------------------
module avl_mem_responder #(
  parameter int ADDR_WIDTH     = 27,
  parameter int DATA_WIDTH     = 576,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int RD_LATENCY     = 4,
  parameter int MAX_PENDING    = 4
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [ADDR_WIDTH-1:0]     s_address,
  input  logic                      s_read,
  input  logic                      s_write,
  input  logic [DATA_WIDTH-1:0]     s_writedata,
  input  logic [DATA_WIDTH/8-1:0]   s_be,
  input  logic [6:0]                s_burstcount,
  output logic                      s_waitrequest,
  output logic [DATA_WIDTH-1:0]     s_readdata,
  output logic                      s_readdatavalid,
  output logic                      proto_err
);

  localparam int BE_W      = DATA_WIDTH / 8;
  localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int PTR_W     = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int CNT_W     = $clog2(MAX_PENDING + 1);

  typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;
  typedef enum logic {W_IDLE, W_BURST} w_state_t;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Command FIFO. A burst stays at the head (and keeps its slot) until its
  // last beat has been issued.
  idx_t       fifo_addr_q [MAX_PENDING];
  logic [6:0] fifo_bc_q   [MAX_PENDING];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] fifo_cnt_q;

  // init holds off the bus for the first clock after reset release.
  logic init_q;

  // Write FSM.
  w_state_t w_state_q, w_state_d;
  logic [6:0] w_rem_q, w_rem_d;
  idx_t       w_idx_q, w_idx_d;

  // Write commit stage: delaying the RAM write by one clock makes a read
  // issued in the same cycle as the write return the old contents.
  logic                  wr_valid_q;
  idx_t                  wr_idx_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [BE_W-1:0]       wr_be_q;

  // Read engine.
  logic [5:0] beat_q;
  logic       issue_valid_q;
  idx_t       issue_idx_q;

  logic [RD_LATENCY-1:0] pipe_valid_q;
  logic [DATA_WIDTH-1:0] pipe_data_q [RD_LATENCY];

  logic proto_err_q;

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  logic cmd_rd, cmd_wr, bc_bad, rd_ok, wr_ok, err_now;
  logic wr_fire;
  idx_t wr_fire_idx;

  assign s_waitrequest = init_q || (fifo_cnt_q == CNT_W'(MAX_PENDING));

  assign cmd_rd = s_read  && !s_waitrequest;
  assign cmd_wr = s_write && !s_waitrequest;
  assign bc_bad = (s_burstcount == 7'd0) || (s_burstcount > 7'd64);

  // A read is rejected during an open write burst; burstcount is only
  // meaningful on the first beat of a write burst.
  assign rd_ok   = cmd_rd && !s_write && !bc_bad && (w_state_q == W_IDLE);
  assign wr_ok   = cmd_wr && !s_read && ((w_state_q == W_BURST) || !bc_bad);
  assign err_now = (cmd_rd || cmd_wr) && !rd_ok && !wr_ok;

  // Upper address bits do not select anything.
  logic unused_addr_bits;
  assign unused_addr_bits = ^s_address[ADDR_WIDTH-1:MEM_DEPTH_LOG2];

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    w_state_d   = w_state_q;
    w_rem_d     = w_rem_q;
    w_idx_d     = w_idx_q;
    wr_fire     = 1'b0;
    wr_fire_idx = w_idx_q;
    case (w_state_q)
      W_IDLE: begin
        if (wr_ok) begin
          wr_fire     = 1'b1;
          wr_fire_idx = s_address[MEM_DEPTH_LOG2-1:0];
          w_idx_d     = s_address[MEM_DEPTH_LOG2-1:0] + idx_t'(1);
          w_rem_d     = s_burstcount - 7'd1;
          if (s_burstcount != 7'd1) w_state_d = W_BURST;
        end
      end
      W_BURST: begin
        if (wr_ok) begin
          wr_fire     = 1'b1;
          wr_fire_idx = w_idx_q;
          w_idx_d     = w_idx_q + idx_t'(1);
          w_rem_d     = w_rem_q - 7'd1;
          if (w_rem_q == 7'd1) w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read engine: issue one beat per cycle from the FIFO head
  // ---------------------------------------------------------------------------
  idx_t       head_addr;
  logic [6:0] head_bc;
  logic       issue_fire, issue_last, push, pop;

  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_bc    = fifo_bc_q[rd_ptr_q];
  assign issue_fire = (fifo_cnt_q != '0);
  assign issue_last = ({1'b0, beat_q} == (head_bc - 7'd1));
  assign push       = rd_ok;
  assign pop        = issue_fire && issue_last;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_PENDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      init_q        <= 1'b1;
      proto_err_q   <= 1'b0;
      w_state_q     <= W_IDLE;
      w_rem_q       <= '0;
      w_idx_q       <= '0;
      wr_valid_q    <= 1'b0;
      wr_idx_q      <= '0;
      wr_data_q     <= '0;
      wr_be_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      beat_q        <= '0;
      issue_valid_q <= 1'b0;
      issue_idx_q   <= '0;
      pipe_valid_q  <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_data_q[i] <= '0;
    end else begin
      init_q <= 1'b0;
      if (err_now) proto_err_q <= 1'b1;

      w_state_q  <= w_state_d;
      w_rem_q    <= w_rem_d;
      w_idx_q    <= w_idx_d;
      wr_valid_q <= wr_fire;
      wr_idx_q   <= wr_fire_idx;
      wr_data_q  <= s_writedata;
      wr_be_q    <= s_be;

      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      fifo_cnt_q <= fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);

      issue_valid_q <= issue_fire;
      issue_idx_q   <= head_addr + idx_t'(beat_q);
      if (issue_fire) beat_q <= issue_last ? 6'd0 : beat_q + 6'd1;

      // Stage 0 is the RAM read; data is zeroed on invalid cycles so the
      // output bus stays quiet between bursts.
      pipe_valid_q[0] <= issue_valid_q;
      pipe_data_q[0]  <= issue_valid_q ? mem[issue_idx_q] : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_data_q[i]  <= pipe_data_q[i-1];
      end
    end
  end

  // FIFO payload only needs to be valid where the count says so.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= s_address[MEM_DEPTH_LOG2-1:0];
      fifo_bc_q[wr_ptr_q]   <= s_burstcount;
    end
  end

  // NOTE: the RAM array is deliberately not reset; contents survive resetn
  // and a reset port on the array would prevent RAM inference.
  always_ff @(posedge clock) begin
    if (wr_valid_q) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be_q[b]) mem[wr_idx_q][b*8 +: 8] <= wr_data_q[b*8 +: 8];
      end
    end
  end

  assign s_readdatavalid = pipe_valid_q[RD_LATENCY-1];
  assign s_readdata      = pipe_data_q[RD_LATENCY-1];
  assign proto_err       = proto_err_q;

endmodule

// File: tb/tb_avl_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_avl_mem_responder
//   Directed bench for avl_mem_responder with default parameters
//   (RD_LATENCY=4, MAX_PENDING=4, depth 1024). Read beats are logged with
//   their cycle number by a negedge monitor; each test task compares the log
//   and the status outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_avl_mem_responder;

  localparam int DW = 576;
  localparam int BW = DW / 8;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic [26:0]   s_address = '0;
  logic          s_read = 1'b0;
  logic          s_write = 1'b0;
  logic [DW-1:0] s_writedata = '0;
  logic [BW-1:0] s_be = '0;
  logic [6:0]    s_burstcount = '0;
  logic          s_waitrequest;
  logic [DW-1:0] s_readdata;
  logic          s_readdatavalid;
  logic          proto_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } beat_t;
  beat_t rx[$];

  avl_mem_responder dut (
    .clock           (clock),
    .resetn          (resetn),
    .s_address       (s_address),
    .s_read          (s_read),
    .s_write         (s_write),
    .s_writedata     (s_writedata),
    .s_be            (s_be),
    .s_burstcount    (s_burstcount),
    .s_waitrequest   (s_waitrequest),
    .s_readdata      (s_readdata),
    .s_readdatavalid (s_readdatavalid),
    .proto_err       (proto_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (s_readdatavalid) rx.push_back('{cyc: cyc, data: s_readdata});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive one write burst; beats after the first carry a junk address.
  task automatic write_burst(input logic [26:0] addr, input logic [6:0] bc,
                             input logic [DW-1:0] data0, input logic [BW-1:0] be);
    for (int k = 0; k < bc; k++) begin
      s_write      = 1'b1;
      s_address    = (k == 0) ? addr : 27'h7ABCDE;
      s_burstcount = bc;
      s_writedata  = data0 + DW'(k);
      s_be         = be;
      for (int g = 0; s_waitrequest; g++) begin
        if (g == 100) begin
          checks++; errors++;
          $display("FAIL write_wait: waitrequest stuck high");
          break;
        end
        tick(1);
      end
      tick(1);
    end
    s_write = 1'b0;
  endtask

  // Hold a read command until accepted; returns the accepting edge number.
  task automatic send_read(input logic [26:0] addr, input logic [6:0] bc, output int acc);
    s_address    = addr;
    s_burstcount = bc;
    s_read       = 1'b1;
    acc          = -1;
    for (int g = 0; g < 200; g++) begin
      if (!s_waitrequest) begin
        tick(1);
        acc = cyc;
        break;
      end
      tick(1);
    end
    s_read = 1'b0;
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL read_accept: read at %0h never accepted", addr);
    end
  endtask

  task automatic test_reset();
    tick(2);
    checks++; if (s_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_waitreq: got %b want 1", s_waitrequest); end
    checks++; if (s_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_rdvalid: got %b want 0", s_readdatavalid); end
    checks++; if (s_readdata !== '0) begin errors++; $display("FAIL rst_rdata: got %0h want 0", s_readdata); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto: got %b want 0", proto_err); end
    resetn = 1'b1;
    #1;
    checks++; if (s_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_init_hold: got %b want 1", s_waitrequest); end
    tick(1);
    checks++; if (s_waitrequest !== 1'b0) begin errors++; $display("FAIL rst_init_clear: got %b want 0", s_waitrequest); end
  endtask

  task automatic test_write_read();
    int acc;
    write_burst(27'h10, 7'd4, DW'('hA0), '1);
    tick(2);
    rx.delete();
    send_read(27'h10, 7'd4, acc);
    tick(14);
    checks++; if (rx.size() !== 4) begin errors++; $display("FAIL wr_rd_count: got %0d want 4", rx.size()); end
    for (int i = 0; i < rx.size() && i < 4; i++) begin
      checks++; if (rx[i].cyc !== acc + 5 + i) begin errors++; $display("FAIL wr_rd_cycle[%0d]: got %0d want %0d", i, rx[i].cyc, acc + 5 + i); end
      checks++; if (rx[i].data !== DW'('hA0 + i)) begin errors++; $display("FAIL wr_rd_data[%0d]: got %0h want %0h", i, rx[i].data, 'hA0 + i); end
    end
  endtask

  task automatic test_byte_enable();
    int acc;
    write_burst(27'h3, 7'd1, '0, '1);
    write_burst(27'h3, 7'd1, '1, BW'(1));
    tick(2);
    rx.delete();
    send_read(27'h3, 7'd1, acc);
    tick(10);
    checks++; if (rx.size() !== 1) begin errors++; $display("FAIL be_count: got %0d want 1", rx.size()); end
    else begin
      checks++; if (rx[0].data !== DW'('hFF)) begin errors++; $display("FAIL be_data: got %0h want ff", rx[0].data); end
    end
  endtask

  task automatic test_fifo_full();
    int acc[5];
    write_burst(27'h100, 7'd40, DW'('hB00), '1);
    tick(2);
    rx.delete();
    for (int i = 0; i < 4; i++) send_read(27'h100 + 27'(8 * i), 7'd8, acc[i]);
    checks++; if (s_waitrequest !== 1'b1) begin errors++; $display("FAIL full_waitreq: got %b want 1", s_waitrequest); end
    checks++; if (acc[3] !== acc[0] + 3) begin errors++; $display("FAIL full_b2b_accept: got %0d want %0d", acc[3], acc[0] + 3); end
    send_read(27'h120, 7'd8, acc[4]);
    checks++; if (acc[4] !== acc[0] + 9) begin errors++; $display("FAIL full_5th_accept: got %0d want %0d", acc[4], acc[0] + 9); end
    tick(50);
    checks++; if (rx.size() !== 40) begin errors++; $display("FAIL full_count: got %0d want 40", rx.size()); end
    for (int i = 0; i < rx.size() && i < 40; i++) begin
      checks++; if (rx[i].cyc !== acc[0] + 5 + i || rx[i].data !== DW'('hB00 + i)) begin
        errors++; $display("FAIL full_beat[%0d]: got cyc %0d data %0h want cyc %0d data %0h",
                           i, rx[i].cyc, rx[i].data, acc[0] + 5 + i, 'hB00 + i);
      end
    end
  endtask

  task automatic test_wrap();
    int acc;
    write_burst(27'd1022, 7'd4, DW'('hC0), '1);
    tick(2);
    rx.delete();
    send_read(27'h0, 7'd2, acc);
    send_read(27'h40003FE, 7'd2, acc);  // upper address bits must be ignored
    tick(12);
    checks++; if (rx.size() !== 4) begin errors++; $display("FAIL wrap_count: got %0d want 4", rx.size()); end
    else begin
      checks++; if (rx[0].data !== DW'('hC2)) begin errors++; $display("FAIL wrap_ram0: got %0h want c2", rx[0].data); end
      checks++; if (rx[1].data !== DW'('hC3)) begin errors++; $display("FAIL wrap_ram1: got %0h want c3", rx[1].data); end
      checks++; if (rx[2].data !== DW'('hC0)) begin errors++; $display("FAIL wrap_ram1022: got %0h want c0", rx[2].data); end
      checks++; if (rx[3].data !== DW'('hC1)) begin errors++; $display("FAIL wrap_ram1023: got %0h want c1", rx[3].data); end
    end
  endtask

  task automatic test_proto_err();
    int acc;
    write_burst(27'h20, 7'd1, DW'('hD0), '1);
    tick(2);
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL perr_pre: got %b want 0", proto_err); end
    rx.delete();
    // burstcount 0 write
    s_write = 1'b1; s_address = 27'h20; s_burstcount = 7'd0; s_writedata = DW'('hEE); s_be = '1;
    tick(1);
    s_write = 1'b0;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_bc0: got %b want 1", proto_err); end
    // simultaneous read and write
    s_read = 1'b1; s_write = 1'b1; s_burstcount = 7'd1; s_writedata = DW'('hEF);
    tick(1);
    s_read = 1'b0; s_write = 1'b0;
    // burstcount above 64
    s_read = 1'b1; s_burstcount = 7'd65;
    tick(1);
    s_read = 1'b0;
    tick(15);
    checks++; if (rx.size() !== 0) begin errors++; $display("FAIL perr_no_valid: got %0d beats want 0", rx.size()); end
    send_read(27'h20, 7'd1, acc);
    tick(10);
    checks++; if (rx.size() !== 1) begin errors++; $display("FAIL perr_read_count: got %0d want 1", rx.size()); end
    else begin
      checks++; if (rx[0].data !== DW'('hD0)) begin errors++; $display("FAIL perr_ram_kept: got %0h want d0", rx[0].data); end
    end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b want 1", proto_err); end
  endtask

  task automatic test_reset_mid_read();
    int acc;
    rx.delete();
    send_read(27'h100, 7'd16, acc);
    tick(6);
    checks++; if (s_readdatavalid !== 1'b1) begin errors++; $display("FAIL mid_valid_before: got %b want 1", s_readdatavalid); end
    resetn = 1'b0;
    #1;
    checks++; if (s_readdatavalid !== 1'b0) begin errors++; $display("FAIL mid_valid_drop: got %b want 0", s_readdatavalid); end
    checks++; if (s_waitrequest !== 1'b1) begin errors++; $display("FAIL mid_waitreq: got %b want 1", s_waitrequest); end
    rx.delete();
    tick(3);
    resetn = 1'b1;
    #1;
    checks++; if (s_waitrequest !== 1'b1) begin errors++; $display("FAIL mid_init_hold: got %b want 1", s_waitrequest); end
    tick(1);
    checks++; if (s_waitrequest !== 1'b0) begin errors++; $display("FAIL mid_init_clear: got %b want 0", s_waitrequest); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL mid_proto_clr: got %b want 0", proto_err); end
    tick(25);
    checks++; if (rx.size() !== 0) begin errors++; $display("FAIL mid_no_stale: got %0d beats want 0", rx.size()); end
    send_read(27'h100, 7'd2, acc);
    tick(10);
    checks++; if (rx.size() !== 2) begin errors++; $display("FAIL mid_after_count: got %0d want 2", rx.size()); end
    else begin
      checks++; if (rx[0].data !== DW'('hB00) || rx[1].data !== DW'('hB01)) begin
        errors++; $display("FAIL mid_after_data: got %0h %0h want b00 b01", rx[0].data, rx[1].data);
      end
    end
  endtask

  task automatic test_read_in_wburst();
    int acc;
    rx.delete();
    s_write = 1'b1; s_address = 27'h30; s_burstcount = 7'd2; s_writedata = DW'('hE0); s_be = '1;
    tick(1);
    s_write = 1'b0;
    s_read = 1'b1; s_address = 27'h30; s_burstcount = 7'd1;
    tick(1);
    s_read = 1'b0;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL wb_proto: got %b want 1", proto_err); end
    s_write = 1'b1; s_address = 27'h55; s_burstcount = 7'd9; s_writedata = DW'('hE1);
    tick(1);
    s_write = 1'b0;
    tick(12);
    checks++; if (rx.size() !== 0) begin errors++; $display("FAIL wb_dropped: got %0d beats want 0", rx.size()); end
    send_read(27'h30, 7'd2, acc);
    tick(12);
    checks++; if (rx.size() !== 2) begin errors++; $display("FAIL wb_count: got %0d want 2", rx.size()); end
    else begin
      checks++; if (rx[0].data !== DW'('hE0) || rx[1].data !== DW'('hE1)) begin
        errors++; $display("FAIL wb_data: got %0h %0h want e0 e1", rx[0].data, rx[1].data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_fifo_full();
    test_wrap();
    test_proto_err();
    test_reset_mid_read();
    test_read_in_wburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
